cache_controller: RTL and testbench
===================================

# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache placed between the MEM stage and `SramController`. Read hits complete in the request cycle. Read misses fetch a 64-bit line through the SRAM controller and fill it. Writes always go through to SRAM. `ready` feeds the pipeline freeze logic: while it is low, the pipeline holds its inputs stable.

## Interface
Parameters:
- SETS, 64, number of sets (index width 6)
- TAG_W, 10, tag width
- BASE_ADDR, 1024, data-memory base subtracted from `address`

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- address  in  32  byte address from MEM stage
- wdata  in  32  store data
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request; has priority if both enables are high
- rdata  out  32  load data
- ready  out  1  request complete; low means stall
- sram_address  out  32  forwarded `address`
- sram_wdata  out  32  forwarded `wdata`
- sram_read  out  1  SRAM read request
- sram_write  out  1  SRAM write request
- sram_rdata  in  64  line from SRAM controller
- sram_ready  in  1  SRAM controller ready

## Operation
- Address decode (a = address − BASE_ADDR):
  - word offset a[2]: 0 selects the low 32 bits of the line, 1 selects the high 32 bits
  - index a[8:3]
  - tag a[18:9]
- Storage: per set and per way, a 64-bit line, TAG_W tag and valid bit; one LRU bit per set, where lru = 0 means way 0 is least recently used.
- Hit: valid and tag match. At most one way can hit.
- States: IDLE, MISS, WRITE.
- IDLE:
  - No request: ready = 1.
  - Read hit: rdata = selected word of the hit way; ready = 1; LRU updated so the hit way becomes MRU; stay in IDLE.
  - Read miss: ready = 0; next state MISS.
  - Write (hit or miss): ready = 0; next state WRITE.
- MISS:
  - sram_read = 1.
  - While sram_ready = 0: ready = 0.
  - When sram_ready = 1:
    - rdata = selected word of sram_rdata; ready = 1.
    - At the clock edge: fill victim way with sram_rdata, the tag, and valid = 1; update LRU; go to IDLE.
  - Victim selection: an invalid way is chosen first (way 0 if both are invalid); otherwise the LRU way.
- WRITE:
  - sram_write = 1.
  - When sram_ready = 1: ready = 1.
    - On a write hit, the cached word in the hit way is updated with wdata at the same edge, and LRU is updated.
    - On a write miss, the cache is unchanged (no allocate).
  - Go to IDLE.
- sram_read and sram_write are never asserted in IDLE and never asserted together.
- sram_ready is ignored in IDLE. The SRAM controller's idle-ready is not treated as completion.
- rdata is don't-care unless a load completes; bench drives 0 otherwise.

## Timing
- Reset:
  - state = IDLE; all valid bits = 0; all LRU bits = 0.
  - ready = 1 when no request is pending; rdata = 0; sram_read = 0; sram_write = 0.
  - Data and tag arrays are not reset.
- Read hit latency: 0 cycles. ready is combinationally high in the request cycle.
- Read miss and write: 1 cycle in IDLE, then N cycles in MISS or WRITE until sram_ready. With the current SRAM controller, total stall ≈ 7 cycles.
- Request inputs are held stable by the pipeline while ready = 0. The block does not register them.
- Reset mid-miss or mid-write: returns to IDLE immediately; no fill occurs; SRAM request signals drop asynchronously.
- Back-to-back: a request in the cycle after completion is evaluated in IDLE normally. A read hit on a just-filled line hits.

## Structure
- Shared package `cache_pkg`:
  - state encoding (IDLE/MISS/WRITE)
  - SETS, TAG_W, INDEX_W, BASE_ADDR
  - address-field slice constants
- Sub-module `cache_set_array`:
  - holds lines, tags, valids and LRU
  - combinational lookup: hit, hit_way, victim_way, read word
  - synchronous fill and word-update ports
  - asynchronous clear of valid and LRU
- `cache_controller` contains the FSM and glue only.

## Test plan
- Reset then load 0x400: IDLE→MISS; sram_read high; on sram_ready with sram_rdata = 0x22222222_11111111, rdata = 0x11111111 and ready = 1; the next load of 0x404 hits with rdata = 0x22222222 in 0 cycles.
- Store 0x400 = 0xDEADBEEF after fill: WRITE state; sram_write high until sram_ready; the next load 0x400 hits and returns 0xDEADBEEF.
- Store to uncached 0x800: sram_write cycle completes; a subsequent load 0x800 misses (no allocate).
- Three tags, same index (0x400, 0x400 + 512, 0x400 + 1024): ways fill 0 then 1; re-read 0x400 (way 0 becomes MRU); the third load evicts way 1; 0x400 still hits.
- Assert rst during MISS with sram_ready low: ready returns to 1, sram_read = 0, and a load of the same address misses again.
- mem_r_en = mem_w_en = 1: treated as a store; sram_write asserted and sram_read never asserted.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// =============================================================================
// Module   : cache_pkg
// Brief    : Shared constants, state encoding and helpers for the data cache.
// Revision : 1.0 - initial release
// =============================================================================
package cache_pkg;

  localparam int SETS      = 64;
  localparam int TAG_W     = 10;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int BASE_ADDR = 1024;

  localparam int LINE_W = 64;
  localparam int WORD_W = 32;

  // Field positions within the base-relative byte offset.
  localparam int WORD_SEL_BIT = 2;
  localparam int INDEX_LSB    = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MISS  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;

  function automatic logic [WORD_W-1:0] select_word(
    input logic [LINE_W-1:0] line,
    input logic              sel
  );
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_set_array.sv
`default_nettype none
// =============================================================================
// Module   : cache_set_array
// Brief    : Two-way line/tag/valid storage with per-set LRU and lookup logic.
// Revision : 1.0 - initial release
// =============================================================================
module cache_set_array #(
  parameter int SETS    = cache_pkg::SETS,
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int INDEX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word_sel,
  output logic               hit,
  output logic               hit_way,
  output logic               victim_way,
  output logic [31:0]        hit_word,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic [63:0]        fill_line,
  input  logic               upd_en,
  input  logic               upd_way,
  input  logic [31:0]        upd_word,
  input  logic               touch_en,
  input  logic               touch_way
);
  import cache_pkg::*;

  logic [1:0]      w_way_hit;
  logic [1:0]      w_way_valid;
  logic [63:0]     w_way_line [2];
  logic [SETS-1:0] r_lru;

  for (genvar gw = 0; gw < 2; gw++) begin : g_way
    localparam logic c_way = 1'(gw);

    logic [63:0]      r_line [SETS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;

    // Data and tags carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
      if (fill_en && (fill_way == c_way)) begin
        r_line[index] <= fill_line;
        r_tag[index]  <= tag;
      end else if (upd_en && (upd_way == c_way)) begin
        if (word_sel) begin
          r_line[index][63:32] <= upd_word;
        end else begin
          r_line[index][31:0] <= upd_word;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= '0;
      end else if (fill_en && (fill_way == c_way)) begin
        r_valid[index] <= 1'b1;
      end
    end

    assign w_way_valid[gw] = r_valid[index];
    assign w_way_hit[gw]   = r_valid[index] && (r_tag[index] == tag);
    assign w_way_line[gw]  = r_line[index];
  end

  // lru holds the least recently used way, so touching a way stores its sibling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lru <= '0;
    end else if (touch_en) begin
      r_lru[index] <= ~touch_way;
    end
  end

  assign hit      = |w_way_hit;
  assign hit_way  = w_way_hit[1];
  assign hit_word = select_word(w_way_line[hit_way], word_sel);

  always_comb begin
    victim_way = 1'b0;
    if (!w_way_valid[0]) begin
      victim_way = 1'b0;
    end else if (!w_way_valid[1]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = r_lru[index];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// =============================================================================
// Module   : cache_controller
// Brief    : Write-through, no-write-allocate 2-way data cache in front of SRAM.
// Revision : 1.0 - initial release
// =============================================================================
module cache_controller #(
  parameter int SETS      = cache_pkg::SETS,
  parameter int TAG_W     = cache_pkg::TAG_W,
  parameter int BASE_ADDR = cache_pkg::BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);
  import cache_pkg::*;

  localparam int c_INDEX_W   = $clog2(SETS);
  localparam int c_INDEX_LSB = INDEX_LSB;
  localparam int c_TAG_LSB   = c_INDEX_LSB + c_INDEX_W;
  localparam int c_USED_W    = c_TAG_LSB + TAG_W;
  // The base is word aligned, so the subtraction starts at the word-select bit.
  localparam logic [c_USED_W-3:0] c_BASE_WORD = (c_USED_W-2)'(BASE_ADDR >> 2);

  logic [c_USED_W-1:2]  w_offset;
  logic                 w_word_sel;
  logic [c_INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]     w_tag;

  logic        w_hit;
  logic        w_hit_way;
  logic        w_victim_way;
  logic [31:0] w_hit_word;
  logic        w_fill_en;
  logic        w_upd_en;
  logic        w_touch_en;
  logic        w_touch_way;

  state_t r_state;
  state_t w_next_state;

  assign w_offset   = address[c_USED_W-1:2] - c_BASE_WORD;
  assign w_word_sel = w_offset[WORD_SEL_BIT];
  assign w_index    = w_offset[c_INDEX_LSB +: c_INDEX_W];
  assign w_tag      = w_offset[c_TAG_LSB +: TAG_W];

  assign sram_address = address;
  assign sram_wdata   = wdata;

  cache_set_array #(
    .SETS    (SETS),
    .TAG_W   (TAG_W),
    .INDEX_W (c_INDEX_W)
  ) u_set_array (
    .clk        (clk),
    .rst        (rst),
    .index      (w_index),
    .tag        (w_tag),
    .word_sel   (w_word_sel),
    .hit        (w_hit),
    .hit_way    (w_hit_way),
    .victim_way (w_victim_way),
    .hit_word   (w_hit_word),
    .fill_en    (w_fill_en),
    .fill_way   (w_victim_way),
    .fill_line  (sram_rdata),
    .upd_en     (w_upd_en),
    .upd_way    (w_hit_way),
    .upd_word   (wdata),
    .touch_en   (w_touch_en),
    .touch_way  (w_touch_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_w_en) begin
          w_next_state = ST_WRITE;
        end else if (mem_r_en && !w_hit) begin
          w_next_state = ST_MISS;
        end
      end
      ST_MISS, ST_WRITE: begin
        if (sram_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // sram_ready is only honoured once a request is outstanding.
  always_comb begin
    ready       = 1'b0;
    rdata       = '0;
    sram_read   = 1'b0;
    sram_write  = 1'b0;
    w_fill_en   = 1'b0;
    w_upd_en    = 1'b0;
    w_touch_en  = 1'b0;
    w_touch_way = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_w_en) begin
          ready = 1'b0;
        end else if (mem_r_en) begin
          if (w_hit) begin
            ready       = 1'b1;
            rdata       = w_hit_word;
            w_touch_en  = 1'b1;
            w_touch_way = w_hit_way;
          end
        end else begin
          ready = 1'b1;
        end
      end
      ST_MISS: begin
        sram_read = 1'b1;
        if (sram_ready) begin
          ready       = 1'b1;
          rdata       = select_word(sram_rdata, w_word_sel);
          w_fill_en   = 1'b1;
          w_touch_en  = 1'b1;
          w_touch_way = w_victim_way;
        end
      end
      ST_WRITE: begin
        sram_write = 1'b1;
        if (sram_ready) begin
          ready = 1'b1;
          if (w_hit) begin
            w_upd_en    = 1'b1;
            w_touch_en  = 1'b1;
            w_touch_way = w_hit_way;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// =============================================================================
// Module   : tb_cache_controller
// Brief    : Randomised bench for cache_controller against a recency-list model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic        mem_r_en, mem_w_en, ready, sram_read, sram_write, sram_ready;
  logic [63:0] sram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  // Backing SRAM keyed by 64-bit line number; untouched lines hold a hash.
  logic [63:0] mem [logic [28:0]];

  function automatic logic [63:0] mem_get(input logic [28:0] k);
    logic [31:0] kk;
    kk = {3'b000, k};
    if (mem.exists(k)) return mem[k];
    return {kk * 32'h9E37_79B1, kk ^ 32'h5A5A_5A5A};
  endfunction

  // Model: each set is a recency list of at most two lines, entry 0 is MRU.
  int          m_cnt  [64];
  logic [9:0]  m_tag  [64][2];
  logic [63:0] m_line [64][2];

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
  endtask

  task automatic model_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                              output bit hit, output logic [31:0] word);
    logic [31:0] a;
    logic [9:0]  tg;
    logic [63:0] line;
    logic [9:0]  t_tmp;
    logic [63:0] l_tmp;
    int          idx, pos;
    bit          hi;
    a   = addr - 32'd1024;
    idx = int'(a[8:3]);
    tg  = a[18:9];
    hi  = a[2];
    pos = -1;
    for (int k = 0; k < m_cnt[idx]; k++) if (m_tag[idx][k] == tg) pos = k;
    hit = (pos >= 0);
    if (pos == 1) begin
      t_tmp = m_tag[idx][0];  m_tag[idx][0]  = m_tag[idx][1];  m_tag[idx][1]  = t_tmp;
      l_tmp = m_line[idx][0]; m_line[idx][0] = m_line[idx][1]; m_line[idx][1] = l_tmp;
    end
    word = 32'h0;
    if (is_wr) begin
      line = mem_get(addr[31:3]);
      if (hi) line[63:32] = data; else line[31:0] = data;
      mem[addr[31:3]] = line;
      if (hit) m_line[idx][0] = line;
    end else begin
      if (!hit) begin
        m_tag[idx][1]  = m_tag[idx][0];
        m_line[idx][1] = m_line[idx][0];
        m_tag[idx][0]  = tg;
        m_line[idx][0] = mem_get(addr[31:3]);
        if (m_cnt[idx] < 2) m_cnt[idx]++;
      end
      line = m_line[idx][0];
      word = hi ? line[63:32] : line[31:0];
    end
  endtask

  // Holds one request until ready, acting as the SRAM controller with a fixed latency.
  task automatic drive(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, output logic [31:0] got, output int cyc,
                       output bit saw_rd, output bit saw_wr, output bit bad);
    int  wait_cnt;
    bit  done;
    wait_cnt = 0; done = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; bad = 1'b0;
    got = 'x; cyc = -1;
    @(negedge clk);
    address = addr; wdata = data; mem_r_en = rd; mem_w_en = wr;
    for (int c = 0; c < 60; c++) begin
      if (sram_read || sram_write) sram_ready = (wait_cnt >= lat);
      else                         sram_ready = 1'($urandom_range(0, 1));
      sram_rdata = (sram_ready && sram_read) ? mem_get(sram_address[31:3]) : {$urandom, $urandom};
      #1;
      if (sram_read)  saw_rd = 1'b1;
      if (sram_write) saw_wr = 1'b1;
      if (sram_read && sram_write) bad = 1'b1;
      if (c == 0 && (sram_read || sram_write)) bad = 1'b1;
      if (sram_address !== addr || sram_wdata !== data) bad = 1'b1;
      if (ready) begin
        got = rdata; cyc = c; done = 1'b1;
        break;
      end
      if (sram_read || sram_write) wait_cnt++;
      @(negedge clk);
    end
    if (!done) bad = 1'b1;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                    input int lat, output logic [31:0] got, output logic [31:0] exp_word,
                    output int cyc, output int exp_cyc, output bit proto_ok);
    bit hit, srd, swr, bad;
    model_access(wr, addr, data, hit, exp_word);
    exp_cyc = (!wr && hit) ? 0 : 1 + lat;
    drive(rd, wr, addr, data, lat, got, cyc, srd, swr, bad);
    proto_ok = !bad && (swr == wr) && (srd == (!wr && !hit));
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b1;
    address = 32'h400; wdata = 32'h0; sram_rdata = 64'h0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (ready !== 1'b1)      begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
    n_vec++; if (rdata !== 32'h0)     begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_vec++; if (sram_read !== 1'b0)  begin n_err++; $display("FAIL reset_sram_read got %b want 0", sram_read); end
    n_vec++; if (sram_write !== 1'b0) begin n_err++; $display("FAIL reset_sram_write got %b want 0", sram_write); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_miss_fill();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    mem[29'h80] = 64'h22222222_11111111;
    op(1'b1, 1'b0, 32'h400, 32'h0, 3, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (got !== 32'h11111111) begin n_err++; $display("FAIL miss_data got %h want 11111111", got); end
    n_vec++; if (cyc !== 4)            begin n_err++; $display("FAIL miss_stall got %0d want 4", cyc); end
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL miss_proto got 0 want 1"); end
    op(1'b1, 1'b0, 32'h404, 32'h0, 0, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (got !== 32'h22222222) begin n_err++; $display("FAIL hit_data got %h want 22222222", got); end
    n_vec++; if (cyc !== 0)            begin n_err++; $display("FAIL hit_stall got %0d want 0", cyc); end
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL hit_proto got 0 want 1"); end
  endtask

  task automatic test_write_hit();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    op(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 2, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 3)            begin n_err++; $display("FAIL whit_stall got %0d want 3", cyc); end
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL whit_proto got 0 want 1"); end
    op(1'b1, 1'b0, 32'h400, 32'h0, 1, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (got !== 32'hDEADBEEF) begin n_err++; $display("FAIL whit_read got %h want deadbeef", got); end
    n_vec++; if (cyc !== 0)            begin n_err++; $display("FAIL whit_read_stall got %0d want 0", cyc); end
  endtask

  task automatic test_write_miss();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    op(1'b0, 1'b1, 32'h800, 32'h0BADF00D, 1, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 2)            begin n_err++; $display("FAIL wmiss_stall got %0d want 2", cyc); end
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL wmiss_proto got 0 want 1"); end
    op(1'b1, 1'b0, 32'h800, 32'h0, 2, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 3)            begin n_err++; $display("FAIL no_alloc_stall got %0d want 3", cyc); end
    n_vec++; if (got !== 32'h0BADF00D) begin n_err++; $display("FAIL no_alloc_data got %h want 0badf00d", got); end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    @(negedge clk);
    address = 32'h448; mem_r_en = 1'b1; mem_w_en = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if (sram_read !== 1'b1) begin n_err++; $display("FAIL rmid_in_miss got %b want 1", sram_read); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (sram_read !== 1'b0) begin n_err++; $display("FAIL rmid_read_drop got %b want 0", sram_read); end
    mem_r_en = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1)     begin n_err++; $display("FAIL rmid_ready got %b want 1", ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    op(1'b1, 1'b0, 32'h448, 32'h0, 1, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 2)          begin n_err++; $display("FAIL rmid_remiss got %0d want 2", cyc); end
    n_vec++; if (got !== exp_w)      begin n_err++; $display("FAIL rmid_data got %h want %h", got, exp_w); end
  endtask

  task automatic test_lru_evict();
    logic [31:0] addrs [6] = '{32'h400, 32'h600, 32'h400, 32'h800, 32'h400, 32'h600};
    bit          hits  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] got, exp_w; int cyc, exp_c, lat; bit ok;
    for (int i = 0; i < 6; i++) begin
      lat = int'($urandom_range(0, 3));
      op(1'b1, 1'b0, addrs[i], 32'h0, lat, got, exp_w, cyc, exp_c, ok);
      n_vec++; if (cyc !== (hits[i] ? 0 : 1 + lat))
        begin n_err++; $display("FAIL lru_stall[%0d] got %0d want %0d", i, cyc, hits[i] ? 0 : 1 + lat); end
      n_vec++; if (got !== exp_w) begin n_err++; $display("FAIL lru_data[%0d] got %h want %h", i, got, exp_w); end
      n_vec++; if (!ok)           begin n_err++; $display("FAIL lru_proto[%0d] got 0 want 1", i); end
    end
  endtask

  task automatic test_both_enables();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    op(1'b1, 1'b1, 32'h404, 32'h12345678, 2, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 3)            begin n_err++; $display("FAIL both_stall got %0d want 3", cyc); end
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL both_proto got 0 want 1"); end
    op(1'b1, 1'b0, 32'h404, 32'h0, 0, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (got !== 32'h12345678) begin n_err++; $display("FAIL both_read got %h want 12345678", got); end
    n_vec++; if (cyc !== 0)            begin n_err++; $display("FAIL both_read_stall got %0d want 0", cyc); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp_w, addr; int cyc, exp_c, lat, sel; bit ok, rd, wr;
    int idx_pool [4] = '{0, 1, 5, 63};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'($urandom_range(0, 1));
        #1;
        n_vec++; if (ready !== 1'b1 || sram_read || sram_write)
          begin n_err++; $display("FAIL idle[%0d] got ready=%b rd=%b wr=%b want 1/0/0", i, ready, sram_read, sram_write); end
      end
      addr = 32'h400 + (32'($urandom_range(0, 3)) << 9) + (32'(idx_pool[$urandom_range(0, 3)]) << 3)
             + (32'($urandom_range(0, 1)) << 2);
      sel = int'($urandom_range(0, 9));
      rd  = (sel < 6) || (sel == 9);
      wr  = (sel >= 6);
      lat = int'($urandom_range(0, 4));
      op(rd, wr, addr, $urandom, lat, got, exp_w, cyc, exp_c, ok);
      n_vec++; if (cyc !== exp_c) begin n_err++; $display("FAIL rnd_stall[%0d] addr %h got %0d want %0d", i, addr, cyc, exp_c); end
      n_vec++; if (!ok)           begin n_err++; $display("FAIL rnd_proto[%0d] addr %h got 0 want 1", i, addr); end
      if (!wr) begin
        n_vec++; if (got !== exp_w) begin n_err++; $display("FAIL rnd_data[%0d] addr %h got %h want %h", i, addr, got, exp_w); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp_w; int cyc, exp_c; bit ok;
    op(1'b1, 1'b0, 32'h7F0, 32'h0, 0, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== exp_c) begin n_err++; $display("FAIL b2b_fill got %0d want %0d", cyc, exp_c); end
    op(1'b1, 1'b0, 32'h7F4, 32'h0, 0, got, exp_w, cyc, exp_c, ok);
    n_vec++; if (cyc !== 0)     begin n_err++; $display("FAIL b2b_hit got %0d want 0", cyc); end
    n_vec++; if (got !== exp_w) begin n_err++; $display("FAIL b2b_data got %h want %h", got, exp_w); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_write_hit();
    test_write_miss();
    test_reset_mid_miss();
    test_lru_evict();
    test_both_enables();
    test_random();
    test_back_to_back();
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
